// File: rtl/stream_arbiter_pkg.sv
// Shared types and sizes for the four-input round-robin stream arbiter.
// Imported by rr_priority_encoder and stream_arbiter.
package stream_arbiter_pkg;

    localparam int N_IN  = 4;
    localparam int IDX_W = 2;

    typedef enum logic [1:0] {
        IDLE,
        ACCEPT,
        SEND
    } state_t;

endpackage

// File: rtl/rr_priority_encoder.sv
// Rotating-priority winner pick: first set request bit at or above ptr,
// wrapping modulo N_IN.
module rr_priority_encoder
    import stream_arbiter_pkg::*;
(
    input  logic [N_IN-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] winner,
    output logic             any_req
);

    logic [IDX_W-1:0] idx;

    // Walk offsets from farthest to nearest so the nearest request wins.
    always_comb begin
        winner  = '0;
        idx     = '0;
        any_req = |req;
        for (int k = N_IN - 1; k >= 0; k--) begin
            idx = ptr + IDX_W'(k);
            if (req[idx]) begin
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/stream_arbiter.sv
// Four-to-one stream arbiter with rotating priority (IDLE/ACCEPT/SEND).
// Define STREAM_ARBITER_WATCHDOG_EN to build the output-stall watchdog.
module stream_arbiter
    import stream_arbiter_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 1023
) (
    input  logic             clk,
    input  logic             rst,
    output logic             exception,
    input  logic [WIDTH-1:0] input_in0,
    input  logic [WIDTH-1:0] input_in1,
    input  logic [WIDTH-1:0] input_in2,
    input  logic [WIDTH-1:0] input_in3,
    input  logic             input_in0_stb,
    input  logic             input_in1_stb,
    input  logic             input_in2_stb,
    input  logic             input_in3_stb,
    output logic             input_in0_ack,
    output logic             input_in1_ack,
    output logic             input_in2_ack,
    output logic             input_in3_ack,
    output logic [WIDTH-1:0] output_out,
    output logic             output_out_stb,
    input  logic             output_out_ack
);

    state_t           state;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] sel;
    logic [IDX_W-1:0] winner;
    logic             any_req;
    logic [N_IN-1:0]  req;
    logic [N_IN-1:0]  ack;
    logic [WIDTH-1:0] sel_data;

    assign req = {input_in3_stb, input_in2_stb,
                  input_in1_stb, input_in0_stb};

    assign input_in0_ack = ack[0];
    assign input_in1_ack = ack[1];
    assign input_in2_ack = ack[2];
    assign input_in3_ack = ack[3];

    rr_priority_encoder u_enc (
        .req     (req),
        .ptr     (ptr),
        .winner  (winner),
        .any_req (any_req)
    );

    always_comb begin
        sel_data = '0;
        unique case (sel)
            2'd0: sel_data = input_in0;
            2'd1: sel_data = input_in1;
            2'd2: sel_data = input_in2;
            2'd3: sel_data = input_in3;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            ptr            <= '0;
            sel            <= '0;
            ack            <= '0;
            output_out     <= '0;
            output_out_stb <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (any_req) begin
                        sel   <= winner;
                        ack   <= N_IN'(1) << winner;
                        state <= ACCEPT;
                    end
                end
                // Latch unconditionally: a producer dropping stb cannot stall us.
                ACCEPT: begin
                    ack            <= '0;
                    output_out     <= sel_data;
                    output_out_stb <= 1'b1;
                    state          <= SEND;
                end
                SEND: begin
                    if (output_out_ack) begin
                        output_out_stb <= 1'b0;
                        ptr            <= sel + IDX_W'(1);
                        state          <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef STREAM_ARBITER_WATCHDOG_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] stall_cnt;

    // Counter saturates at TIMEOUT; exception is sticky until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            exception <= 1'b0;
        end else if (state == SEND) begin
            if (output_out_ack) begin
                stall_cnt <= '0;
            end else begin
                if (stall_cnt != CNT_W'(TIMEOUT)) begin
                    stall_cnt <= stall_cnt + CNT_W'(1);
                end
                if (int'(stall_cnt) + 1 >= TIMEOUT) begin
                    exception <= 1'b1;
                end
            end
        end
    end
`else
    assign exception = 1'b0;
`endif

endmodule

// File: tb/tb_stream_arbiter.sv
// Randomized self-checking bench for stream_arbiter against a
// transaction-level round-robin reference model.
module tb_stream_arbiter;

    localparam int W  = 32;
    localparam int TO = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         exception;
    logic [W-1:0] din [4];
    logic [3:0]   stb;
    logic         a0, a1, a2, a3;
    wire  [3:0]   ack = {a3, a2, a1, a0};
    logic [W-1:0] out;
    logic         out_stb;
    logic         out_ack;

    always #5 clk = ~clk;

    stream_arbiter #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .clk            (clk),
        .rst            (rst),
        .exception      (exception),
        .input_in0      (din[0]),
        .input_in1      (din[1]),
        .input_in2      (din[2]),
        .input_in3      (din[3]),
        .input_in0_stb  (stb[0]),
        .input_in1_stb  (stb[1]),
        .input_in2_stb  (stb[2]),
        .input_in3_stb  (stb[3]),
        .input_in0_ack  (a0),
        .input_in1_ack  (a1),
        .input_in2_ack  (a2),
        .input_in3_ack  (a3),
        .output_out     (out),
        .output_out_stb (out_stb),
        .output_out_ack (out_ack)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t",
                      tag, got, exp, $time);
    endtask

    function automatic int rr_pick(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++)
            if (r[(p + k) % 4]) return (p + k) % 4;
        return -1;
    endfunction

    // Producer / consumer controls
    int           remaining [4] = '{0, 0, 0, 0};
    bit           done [4]      = '{0, 0, 0, 0};
    bit           fixed_en [4]  = '{0, 0, 0, 0};
    logic [W-1:0] fixed_val     = '0;
    bit           rand_mode     = 0;
    int           ack_mode      = 0;

    int           grants [$];
    logic [W-1:0] delivered [$];

    // Reference model state
    bit           m_idle_prev = 0;
    logic [3:0]   m_stb_prev  = '0;
    int           m_ptr       = 0;
    int           m_sel       = 0;
    bit           m_sending   = 0;
    logic [W-1:0] m_out       = '0;
    int           m_cnt       = 0;
    bit           m_exc       = 0;

    always @(negedge clk) begin
        logic [3:0] exp_ack;
        bit         accept;
        bit         idle_now;
        bit         send_next;
        if (rst) begin
            m_idle_prev = 0;
            m_stb_prev  = stb;
            m_ptr       = 0;
            m_sel       = 0;
            m_sending   = 0;
            m_out       = '0;
            m_cnt       = 0;
            m_exc       = 0;
        end else begin
            exp_ack = '0;
            if (m_idle_prev && m_stb_prev != 0)
                exp_ack[rr_pick(m_stb_prev, m_ptr)] = 1'b1;
            check("ack", 64'(ack), 64'(exp_ack));
            check("out_stb", 64'(out_stb), 64'(m_sending));
            check("out_data", 64'(out), 64'(m_out));
            check("exception", 64'(exception), 64'(m_exc));
            for (int i = 0; i < 4; i++) begin
                if (ack[i]) grants.push_back(i);
                if (ack[i] && stb[i]) done[i] = 1;
            end
            if (out_stb && out_ack) delivered.push_back(out);
            accept   = exp_ack != 0;
            idle_now = !accept && !m_sending;
            if (m_sending && out_ack) begin
                m_ptr = (m_sel + 1) % 4;
                m_cnt = 0;
            end else if (m_sending) begin
                m_cnt++;
`ifdef STREAM_ARBITER_WATCHDOG_EN
                if (m_cnt >= TO) m_exc = 1;
`endif
            end
            send_next = accept || (m_sending && !out_ack);
            if (accept) begin
                m_sel = rr_pick(m_stb_prev, m_ptr);
                m_out = din[m_sel];
            end
            m_sending   = send_next;
            m_idle_prev = idle_now;
            m_stb_prev  = stb;
        end
    end

    // Drivers update just after each rising edge
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < 4; i++) begin
            if (done[i]) begin
                done[i] = 0;
                remaining[i]--;
                if (remaining[i] > 0 && !rand_mode)
                    din[i] = fixed_en[i] ? fixed_val : W'($urandom);
                else
                    stb[i] = 1'b0;
            end else if (!stb[i] && remaining[i] > 0 &&
                         (!rand_mode || $urandom_range(2) == 0)) begin
                stb[i] = 1'b1;
                din[i] = fixed_en[i] ? fixed_val : W'($urandom);
            end
        end
        case (ack_mode)
            0:       out_ack = 1'b0;
            1:       out_ack = 1'b1;
            default: out_ack = 1'($urandom_range(1));
        endcase
    end

    function automatic bit busy();
        int s = 0;
        for (int i = 0; i < 4; i++) s += remaining[i];
        return s != 0 || stb != 0 || out_stb;
    endfunction

    task automatic wait_drain(input string tag, input int budget);
        int n = 0;
        while (busy() && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 64'(n < budget), 64'd1);
    endtask

    task automatic wait_out_stb(input string tag, input int budget);
        int n = 0;
        while (!out_stb && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 64'(n < budget), 64'd1);
    endtask

    task automatic pulse_rst();
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        int dups;
        rst     = 1'b1;
        out_ack = 1'b0;
        stb     = '0;
        for (int i = 0; i < 4; i++) din[i] = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // All four requesting continuously from reset
        @(negedge clk);
        check("reset_out_stb", 64'(out_stb), 64'd0);
        check("reset_out", 64'(out), 64'd0);
        ack_mode = 1;
        for (int i = 0; i < 4; i++) remaining[i] = 3;
        wait_drain("drain_all4", 400);
        check("all4_count", 64'(grants.size()), 64'd12);
        for (int i = 0; i < 5; i++)
            check("all4_order", 64'(grants[i]), 64'(i % 4));
        dups = 0;
        for (int i = 1; i < grants.size(); i++)
            if (grants[i] == grants[i-1]) dups++;
        check("all4_no_repeat", 64'(dups), 64'd0);

        // Single request on in2
        pulse_rst();
        grants.delete();
        delivered.delete();
        @(negedge clk);
        fixed_en[2]  = 1;
        fixed_val    = 32'hDEADBEEF;
        remaining[2] = 1;
        wait_drain("drain_single", 50);
        fixed_en[2] = 0;
        check("single_grant", 64'(grants[0]), 64'd2);
        check("single_data", 64'(delivered[0]), 64'hDEADBEEF);

        // Backpressure for 50 cycles
        ack_mode     = 0;
        remaining[0] = 1;
        wait_out_stb("bp_out_stb", 20);
        repeat (50) @(negedge clk);
        check("bp_held", 64'(delivered.size()), 64'd1);
        check("bp_grants", 64'(grants.size()), 64'd2);
`ifdef STREAM_ARBITER_WATCHDOG_EN
        check("bp_exception", 64'(exception), 64'd1);
`else
        check("bp_exception", 64'(exception), 64'd0);
`endif
        ack_mode = 1;
        wait_drain("drain_bp", 50);
        check("bp_delivered", 64'(delivered.size()), 64'd2);

        // Reset during SEND, then in3 served normally
        ack_mode     = 0;
        remaining[1] = 1;
        wait_out_stb("rst_out_stb", 20);
        pulse_rst();
        @(negedge clk);
        check("rst_out_stb", 64'(out_stb), 64'd0);
        check("rst_exception", 64'(exception), 64'd0);
        ack_mode     = 1;
        remaining[3] = 1;
        wait_drain("drain_in3", 50);
        check("rst_in3_grant", 64'(grants[$]), 64'd3);

        // in1 alone moves ptr to 2, then in1 and in3 together
        remaining[1] = 1;
        wait_drain("drain_in1", 50);
        @(negedge clk);
        remaining[1] = 1;
        remaining[3] = 1;
        wait_drain("drain_in13", 50);
        check("ptr2_first", 64'(grants[grants.size()-2]), 64'd3);
        check("ptr2_second", 64'(grants[$]), 64'd1);

        // Randomized traffic with random backpressure
        rand_mode = 1;
        ack_mode  = 2;
        for (int i = 0; i < 4; i++) remaining[i] = $urandom_range(25, 5);
        wait_drain("drain_random", 5000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
